fib_controller: RTL and testbench
=================================

// Module: fib_controller
// PURPOSE
//  FSM that drives the Fibonacci datapath (4-deep register file, ALU, zero flag).
//  On start: loads the iteration count, initialises the Fibonacci seeds, then repeats a
//  4-step update loop until the counter register reaches zero.
//  Sits beside the datapath in the top level; all datapath control inputs come from here.
// PARAMETERS
//  AW   2  register-file address width
//  OPW  3  ALU opcode width
//  CW   4  iteration-counter width (matches datapath count/data width)
// PORTS
//  clk         in   1    system clock, rising edge
//  rst_n       in   1    asynchronous active-low reset
//  start       in   1    begin a run; sampled in IDLE only
//  abort       in   1    return to IDLE at next edge, from any state
//  zero_flag   in   1    datapath ALU zero flag (combinational, same cycle as opcode)
//  wrt_addr    out  AW   register-file write address
//  rd_addr1    out  AW   register-file read port 1 address
//  rd_addr2    out  AW   register-file read port 2 address
//  wrt_en      out  1    register-file write enable
//  load_data   out  1    select external count as write data
//  alu_opcode  out  OPW  ALU operation
//  busy        out  1    high in every state except IDLE
//  done        out  1    one-cycle pulse in DONE
//  iter        out  CW   completed loop iterations; saturates at 2^CW-1
// BEHAVIOUR
//  Opcodes: NOP 000, ONE 001 (write const 1), DEC 011, LOAD 100, TEST 101 (r0->flag, no write),
//   ADD 110 (rd1+rd2), PASS 111 (rd1). Registers: r0 counter, r1 fib, r2 prev, r3 temp.
//  Moore outputs decoded from a registered state. Unlisted fields are 0; wrt_en=1 unless noted.
//   IDLE : NOP, wrt_en=0                      INIT2 : ONE, wa=r2
//   LOAD : LOAD, wa=r0, load_data=1           TEST  : TEST, rd1=r0, wrt_en=0
//   INIT1: ONE, wa=r1                         COPY  : PASS, rd1=r1, wa=r3
//   ADD  : ADD, rd1=r1, rd2=r2, wa=r1         MOVE  : PASS, rd1=r3, wa=r2
//   DEC  : DEC, rd1=r0, wa=r0                 DONE  : NOP, wrt_en=0, done=1
//  Transitions:
//   IDLE -(start & !abort)-> LOAD -> INIT1 -> INIT2 -> TEST
//   TEST: zero_flag -> DONE, else COPY;  COPY -> ADD -> MOVE -> DEC
//   DEC : zero_flag -> DONE, else COPY;  DONE -> IDLE
//  zero_flag is sampled on the clock edge that ends TEST or DEC; ignored in other states.
//  iter: cleared on entry to LOAD; +1 on every edge leaving DEC; holds at max.
//  Latency: count=N -> DONE entered 4+4N cycles after the LOAD cycle; N=0 -> 4 cycles.
//  start while busy: ignored. start & abort together in IDLE: abort wins, stays IDLE.
//  abort: the current state's outputs still apply in that cycle (its write completes);
//   next state IDLE; iter holds; no done pulse.
//  Async reset: state IDLE, all outputs 0, iter 0, immediately on rst_n low, mid-run included.
//  r1 wraps modulo 2^CW; no overflow detection.
// STRUCTURE
//  Shared package fib_pkg: opcode constants (OP_NOP..OP_PASS), register indices (R_CNT,
//   R_FIB, R_PREV, R_TMP), state encoding. Single module, no sub-modules; the output
//   decoder is a case on state.
// TESTING  (controller bound to datapath, 10 ns clock)
//  Reset mid-run (rst_n low in ADD) -> next sample IDLE, wrt_en=0, busy=0, iter=0.
//  count=0, start -> LOAD,INIT1,INIT2,TEST,DONE; done one cycle; iter=0; no COPY state.
//  count=3, start -> 3 loop passes, done 16 cycles after LOAD, iter=3, r1=5, r2=3.
//  count=5 -> r1=13, iter=5; start pulsed during run -> no effect, no extra LOAD.
//  abort in MOVE of pass 2, count=4 -> IDLE next edge, r2 write completes, no done, iter=1.
//  start & abort together in IDLE -> stays IDLE, busy=0; count=15 -> iter=15, r1=1597 mod 16=13.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci controller: ALU opcodes, register-file
// indices and the FSM state encoding.
package fib_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ONE  = 3'b001;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_TEST = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [1:0] R_CNT  = 2'd0;
    localparam logic [1:0] R_FIB  = 2'd1;
    localparam logic [1:0] R_PREV = 2'd2;
    localparam logic [1:0] R_TMP  = 2'd3;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LOAD  = 4'd1;
    localparam logic [3:0] S_INIT1 = 4'd2;
    localparam logic [3:0] S_INIT2 = 4'd3;
    localparam logic [3:0] S_TEST  = 4'd4;
    localparam logic [3:0] S_COPY  = 4'd5;
    localparam logic [3:0] S_ADD   = 4'd6;
    localparam logic [3:0] S_MOVE  = 4'd7;
    localparam logic [3:0] S_DEC   = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

endpackage

// File: rtl/fib_controller.sv
// Moore FSM sequencing the Fibonacci datapath: load count, seed r1/r2, then
// loop COPY/ADD/MOVE/DEC until the counter register reaches zero.
module fib_controller
    import fib_pkg::*;
#(
    parameter int AW  = 2,
    parameter int OPW = 3,
    parameter int CW  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic           zero_flag,
    output logic [AW-1:0]  wrt_addr,
    output logic [AW-1:0]  rd_addr1,
    output logic [AW-1:0]  rd_addr2,
    output logic           wrt_en,
    output logic           load_data,
    output logic [OPW-1:0] alu_opcode,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  iter
);

    logic [3:0] state;
    logic [3:0] state_nxt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (&v)
            return v;
        return v + CW'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_LOAD;
                S_LOAD:  state_nxt = S_INIT1;
                S_INIT1: state_nxt = S_INIT2;
                S_INIT2: state_nxt = S_TEST;
                S_TEST:  state_nxt = zero_flag ? S_DONE : S_COPY;
                S_COPY:  state_nxt = S_ADD;
                S_ADD:   state_nxt = S_MOVE;
                S_MOVE:  state_nxt = S_DEC;
                S_DEC:   state_nxt = zero_flag ? S_DONE : S_COPY;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // An aborted edge leaves iter untouched, even when leaving DEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter <= '0;
        end else if (!abort) begin
            if (state == S_IDLE && start)
                iter <= '0;
            else if (state == S_DEC)
                iter <= sat_inc(iter);
        end
    end

    always_comb begin
        wrt_addr   = '0;
        rd_addr1   = '0;
        rd_addr2   = '0;
        wrt_en     = 1'b0;
        load_data  = 1'b0;
        alu_opcode = OPW'(OP_NOP);
        done       = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_LOAD: begin
                alu_opcode = OPW'(OP_LOAD);
                wrt_addr   = AW'(R_CNT);
                load_data  = 1'b1;
                wrt_en     = 1'b1;
            end
            S_INIT1: begin
                alu_opcode = OPW'(OP_ONE);
                wrt_addr   = AW'(R_FIB);
                wrt_en     = 1'b1;
            end
            S_INIT2: begin
                alu_opcode = OPW'(OP_ONE);
                wrt_addr   = AW'(R_PREV);
                wrt_en     = 1'b1;
            end
            S_TEST: begin
                alu_opcode = OPW'(OP_TEST);
                rd_addr1   = AW'(R_CNT);
            end
            S_COPY: begin
                alu_opcode = OPW'(OP_PASS);
                rd_addr1   = AW'(R_FIB);
                wrt_addr   = AW'(R_TMP);
                wrt_en     = 1'b1;
            end
            S_ADD: begin
                alu_opcode = OPW'(OP_ADD);
                rd_addr1   = AW'(R_FIB);
                rd_addr2   = AW'(R_PREV);
                wrt_addr   = AW'(R_FIB);
                wrt_en     = 1'b1;
            end
            S_MOVE: begin
                alu_opcode = OPW'(OP_PASS);
                rd_addr1   = AW'(R_TMP);
                wrt_addr   = AW'(R_PREV);
                wrt_en     = 1'b1;
            end
            S_DEC: begin
                alu_opcode = OPW'(OP_DEC);
                rd_addr1   = AW'(R_CNT);
                wrt_addr   = AW'(R_CNT);
                wrt_en     = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fib_controller.sv
// Bench for fib_controller: behavioural 4-entry register file and ALU supply
// zero_flag; directed runs compare against hand-computed results.
module tb_fib_controller;
    import fib_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       zero_flag;
    logic [1:0] wrt_addr, rd_addr1, rd_addr2;
    logic       wrt_en, load_data, busy, done;
    logic [2:0] alu_opcode;
    logic [3:0] iter;

    logic [3:0] count = 4'd0;
    logic [3:0] rf [4];
    logic [3:0] alu_res;
    logic [3:0] wdata;

    int checks = 0;
    int failures = 0;

    fib_controller #(.AW(2), .OPW(3), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .zero_flag(zero_flag), .wrt_addr(wrt_addr), .rd_addr1(rd_addr1),
        .rd_addr2(rd_addr2), .wrt_en(wrt_en), .load_data(load_data),
        .alu_opcode(alu_opcode), .busy(busy), .done(done), .iter(iter)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_res = 4'd0;
        case (alu_opcode)
            OP_ONE:  alu_res = 4'd1;
            OP_DEC:  alu_res = rf[rd_addr1] - 4'd1;
            OP_LOAD: alu_res = count;
            OP_TEST: alu_res = rf[rd_addr1];
            OP_ADD:  alu_res = rf[rd_addr1] + rf[rd_addr2];
            OP_PASS: alu_res = rf[rd_addr1];
            default: alu_res = 4'd0;
        endcase
        zero_flag = (alu_res == 4'd0);
        wdata = load_data ? count : alu_res;
    end

    always @(posedge clk) begin
        if (wrt_en)
            rf[wrt_addr] <= wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [12:0] pk(int wa, int r1, int r2, int we, int ld, int op, int bz, int dn);
        return {wa[1:0], r1[1:0], r2[1:0], we[0], ld[0], op[2:0], bz[0], dn[0]};
    endfunction

    function automatic logic [12:0] outs();
        return {wrt_addr, rd_addr1, rd_addr2, wrt_en, load_data, alu_opcode, busy, done};
    endfunction

    task automatic run_seq(input string nm, input int cnt, input logic [12:0] exp_q[$]);
        count = cnt[3:0];
        start = 1'b1;
        step();
        start = 1'b0;
        foreach (exp_q[i]) begin
            check($sformatf("%s[%0d]", nm, i), {19'd0, outs()}, {19'd0, exp_q[i]});
            step();
        end
    endtask

    typedef struct {
        int cnt;
        int exp_iter;
        int exp_r1;
        int exp_r2;
        int exp_cyc;
        bit pulse;
    } run_t;

    initial begin
        run_t runs[6];
        logic [12:0] q0[$];
        logic [12:0] q1[$];
        logic [12:0] l_load, l_init1, l_init2, l_test, l_copy, l_add, l_move, l_dec, l_done;
        int n;
        int loads;

        l_load  = pk(0, 0, 0, 1, 1, 4, 1, 0);
        l_init1 = pk(1, 0, 0, 1, 0, 1, 1, 0);
        l_init2 = pk(2, 0, 0, 1, 0, 1, 1, 0);
        l_test  = pk(0, 0, 0, 0, 0, 5, 1, 0);
        l_copy  = pk(3, 1, 0, 1, 0, 7, 1, 0);
        l_add   = pk(1, 1, 2, 1, 0, 6, 1, 0);
        l_move  = pk(2, 3, 0, 1, 0, 7, 1, 0);
        l_dec   = pk(0, 0, 0, 1, 0, 3, 1, 0);
        l_done  = pk(0, 0, 0, 0, 0, 0, 1, 1);
        q0 = '{l_load, l_init1, l_init2, l_test, l_done, 13'd0};
        q1 = '{l_load, l_init1, l_init2, l_test, l_copy, l_add, l_move, l_dec, l_done, 13'd0};

        runs[0] = '{3, 3, 5, 3, 16, 1'b0};
        runs[1] = '{0, 0, 1, 1, 4, 1'b0};
        runs[2] = '{1, 1, 2, 1, 8, 1'b0};
        runs[3] = '{2, 2, 3, 2, 12, 1'b0};
        runs[4] = '{5, 5, 13, 8, 24, 1'b1};
        runs[5] = '{15, 15, 13, 11, 64, 1'b0};

        #2;
        check("reset_outs", {19'd0, outs()}, 32'd0);
        check("reset_iter", {28'd0, iter}, 32'd0);
        #21;
        rst_n = 1'b1;
        step();
        check("idle_after_reset", {19'd0, outs()}, 32'd0);

        run_seq("seq_cnt1", 1, q1);
        run_seq("seq_cnt0", 0, q0);

        for (int r = 0; r < 6; r++) begin
            count = runs[r].cnt[3:0];
            start = 1'b1;
            step();
            start = 1'b0;
            n = 0;
            loads = 0;
            while (!done && n < 200) begin
                if (load_data) loads++;
                if (runs[r].pulse && (n == 6 || n == 20)) start = 1'b1;
                step();
                start = 1'b0;
                n++;
            end
            check($sformatf("cycles_cnt%0d", runs[r].cnt), n, runs[r].exp_cyc);
            check($sformatf("iter_cnt%0d", runs[r].cnt), {28'd0, iter}, runs[r].exp_iter);
            check($sformatf("r1_cnt%0d", runs[r].cnt), {28'd0, rf[1]}, runs[r].exp_r1);
            check($sformatf("r2_cnt%0d", runs[r].cnt), {28'd0, rf[2]}, runs[r].exp_r2);
            check($sformatf("loads_cnt%0d", runs[r].cnt), loads, 1);
            step();
            check($sformatf("idle_cnt%0d", runs[r].cnt), {31'd0, busy}, 0);
        end

        // Asynchronous reset while in ADD of the second pass.
        count = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(alu_opcode == OP_ADD && iter == 4'd1) && n < 100) begin
            step();
            n++;
        end
        check("rst_reach_add", {31'd0, n < 100}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_wrt_en", {31'd0, wrt_en}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_iter", {28'd0, iter}, 0);
        check("rst_outs", {19'd0, outs()}, 0);
        step();
        #2;
        rst_n = 1'b1;
        step();
        check("rst_stays_idle", {31'd0, busy}, 0);

        // Abort in MOVE of pass 2.
        count = 4'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(alu_opcode == OP_PASS && rd_addr1 == R_TMP && iter == 4'd1) && n < 100) begin
            step();
            n++;
        end
        check("abort_reach_move", {31'd0, n < 100}, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_r2", {28'd0, rf[2]}, 2);
        check("abort_r1", {28'd0, rf[1]}, 3);
        check("abort_iter", {28'd0, iter}, 1);
        step();
        check("abort_no_done", {31'd0, done | busy}, 0);

        // start together with abort in IDLE.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", {31'd0, busy}, 0);
        check("start_abort_iter", {28'd0, iter}, 1);
        step();
        check("start_abort_idle", {19'd0, outs()}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
